// File: rtl/datapath_unit_if.sv
// rtl/datapath_unit_if.sv - controller-to-datapath instruction and status bundle
interface datapath_unit_if;
    logic        WE;
    logic        ALUorM;
    logic [2:0]  ALUCntr;
    logic        ALUSrc2;
    logic [1:0]  RDst3;
    logic [1:0]  RSrc1;
    logic [7:0]  Src2;
    logic [3:0]  ALUFlags;
    logic [7:0]  Result;
    logic [31:0] RegView;

    modport master (
        output WE, ALUorM, ALUCntr, ALUSrc2, RDst3, RSrc1, Src2,
        input  ALUFlags, Result, RegView
    );

    modport slave (
        input  WE, ALUorM, ALUCntr, ALUSrc2, RDst3, RSrc1, Src2,
        output ALUFlags, Result, RegView
    );
endinterface

// File: rtl/datapath_unit.sv
// rtl/datapath_unit.sv - 4x8 register file, 8-bit ALU, lookup RAM and NZCV flags; DATAPATH_SAT_EN enables ADD/SUB saturation
module datapath_unit #(
    parameter int DMEM_DEPTH = 16,
    parameter int DATA_W     = 8
) (
    input logic            clk,
    input logic            reset,
    datapath_unit_if.slave dp
);
    localparam int AW  = $clog2(DMEM_DEPTH);
    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0] rf   [4];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];
    logic [3:0]        flags;

    logic [DATA_W-1:0] a, b, alu_res, wb;
    logic [DATA_W:0]   sum;
    logic              n, z, c, v;

    assign a = rf[dp.RSrc1];
    assign b = dp.ALUSrc2 ? dp.Src2 : rf[dp.Src2[1:0]];

    always_comb begin
        sum     = '0;
        alu_res = '0;
        c       = 1'b0;
        v       = 1'b0;
        case (dp.ALUCntr)
            3'b000: begin
                sum     = {1'b0, a} + {1'b0, b};
                alu_res = sum[MSB:0];
                c       = sum[DATA_W];
                v       = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            3'b001: begin
                // carry out of A + ~B + 1 is the inverted borrow
                sum     = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
                alu_res = sum[MSB:0];
                c       = sum[DATA_W];
                v       = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
            end
            3'b010:  alu_res = a & b;
            3'b011:  alu_res = a | b;
            3'b100:  alu_res = a ^ b;
            3'b101:  alu_res = a << b[2:0];
            3'b110:  alu_res = a >> b[2:0];
            default: alu_res = b;
        endcase
`ifdef DATAPATH_SAT_EN
        // overflow direction follows the sign of A for both ADD and SUB
        if (v) begin
            alu_res = a[MSB] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
`endif
    end

    assign n  = alu_res[MSB];
    assign z  = (alu_res == '0);
    assign wb = dp.ALUorM ? dmem[alu_res[AW-1:0]] : alu_res;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                rf[k] <= '0;
            end
            for (int k = 0; k < DMEM_DEPTH; k++) begin
                dmem[k] <= DATA_W'(k);
            end
            flags <= 4'b0000;
        end else begin
            flags <= {n, z, c, v};
            if (dp.WE) begin
                rf[dp.RDst3] <= wb;
            end
        end
    end

    assign dp.ALUFlags = flags;
    assign dp.Result   = wb;
    assign dp.RegView  = {rf[3], rf[2], rf[1], rf[0]};
endmodule
